// File: rtl/uart_pkg.sv
// Shared UART definitions: capture-state encoding and default payload/FIFO sizes.
package uart_pkg;

  typedef enum logic {
    CAP_IDLE = 1'b0,
    CAP_CLR  = 1'b1
  } cap_state_t;

  localparam int UART_DATA_BITS = 8;
  localparam int RX_FIFO_DEPTH  = 16;

endpackage

// File: rtl/uart_rx_buffer_if.sv
// Receiver-side level handshake plus the buffered valid/ready byte stream and status.
interface uart_rx_buffer_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS,
  parameter int DEPTH     = RX_FIFO_DEPTH
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                 rx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_ready_clr;
  logic [DATA_BITS-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;
  logic [CNT_W-1:0]     count;
  logic                 overrun;
  logic                 overrun_clr;

  modport slave (
    input  rx_ready, rx_data, m_ready, overrun_clr,
    output rx_ready_clr, m_data, m_valid, count, overrun
  );

  modport master (
    output rx_ready, rx_data, m_ready, overrun_clr,
    input  rx_ready_clr, m_data, m_valid, count, overrun
  );
endinterface

// File: rtl/uart_rx_buffer_sync_fifo.sv
// Generic show-ahead synchronous FIFO; 1-cycle push-to-visible latency.
// A push while full is refused unless a pop happens in the same cycle.
module sync_fifo #(
  parameter  int DATA_BITS = 8,
  parameter  int DEPTH     = 16,
  localparam int CNT_W     = $clog2(DEPTH) + 1,
  localparam int PTR_W     = $clog2(DEPTH)
) (
  input  logic                 clk_50m,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_BITS-1:0] din,
  output logic [DATA_BITS-1:0] dout,
  output logic [CNT_W-1:0]     count,
  output logic                 full,
  output logic                 empty
);

  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic                 w_wr_en;
  logic                 w_rd_en;

  assign full    = (r_count == CNT_W'(DEPTH));
  assign empty   = (r_count == '0);
  assign w_rd_en = pop && !empty;
  assign w_wr_en = push && (!full || w_rd_en);
  assign dout    = r_mem[r_rd_ptr];
  assign count   = r_count;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is deliberately left unreset; only the pointers define contents.
  always_ff @(posedge clk_50m) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_rx_buffer.sv
// Captures each UART receiver frame into a FIFO and acks it with a one-cycle ready_clr pulse.
// Frame-to-m_valid latency 1 clock; sink back-pressure is absorbed by the FIFO, overflow drops and sets overrun.
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS,
  parameter int DEPTH     = RX_FIFO_DEPTH
) (
  input logic            clk_50m,
  input logic            rst_n,
  uart_rx_buffer_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  cap_state_t           r_state;
  cap_state_t           w_state_nxt;
  logic                 w_capture;
  logic                 w_clr;
  logic                 w_pop;
  logic                 w_drop;
  logic                 w_full;
  logic                 w_empty;
  logic [CNT_W-1:0]     w_count;
  logic [DATA_BITS-1:0] w_dout;
  logic                 r_overrun;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) r_state <= CAP_IDLE;
    else        r_state <= w_state_nxt;
  end

  // CLR ignores rx_ready: the receiver only drops it at the edge after seeing the clear.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CAP_IDLE: if (bus.rx_ready) w_state_nxt = CAP_CLR;
      CAP_CLR:  w_state_nxt = CAP_IDLE;
      default:  w_state_nxt = CAP_IDLE;
    endcase
  end

  always_comb begin
    w_capture = 1'b0;
    w_clr     = 1'b0;
    case (r_state)
      CAP_IDLE: w_capture = bus.rx_ready;
      CAP_CLR:  w_clr     = 1'b1;
      default:  w_clr     = 1'b0;
    endcase
  end

  assign w_pop  = !w_empty && bus.m_ready;
  assign w_drop = w_capture && w_full && !w_pop;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n)              r_overrun <= 1'b0;
    else if (w_drop)         r_overrun <= 1'b1;
    else if (bus.overrun_clr) r_overrun <= 1'b0;
  end

  sync_fifo #(
    .DATA_BITS(DATA_BITS),
    .DEPTH    (DEPTH)
  ) u_fifo (
    .clk_50m(clk_50m),
    .rst_n  (rst_n),
    .push   (w_capture),
    .pop    (w_pop),
    .din    (bus.rx_data),
    .dout   (w_dout),
    .count  (w_count),
    .full   (w_full),
    .empty  (w_empty)
  );

  // rx_ready_clr is the CLR state flop itself, so it is glitch-free.
  assign bus.rx_ready_clr = w_clr;
  assign bus.m_data       = w_dout;
  assign bus.m_valid      = !w_empty;
  assign bus.count        = w_count;
  assign bus.overrun      = r_overrun;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Randomized bench: behavioural receiver + queue-based reference model, scoreboard monitor on pops.
module tb_uart_rx_buffer;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic clk_50m;
  logic rst_n;

  uart_rx_buffer_if #(.DATA_BITS(DW), .DEPTH(DEPTH)) bus ();

  uart_rx_buffer #(.DATA_BITS(DW), .DEPTH(DEPTH)) dut (
    .clk_50m(clk_50m),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  initial clk_50m = 1'b0;
  always #10 clk_50m = ~clk_50m;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- sink ready driver ----------------
  int   mr_mode   = 0;
  logic mr_manual = 1'b0;

  always @(posedge clk_50m) begin
    #2;
    case (mr_mode)
      0:       bus.m_ready = mr_manual;
      1:       bus.m_ready = ~bus.m_ready;
      default: bus.m_ready = ($urandom_range(0, 3) == 0);
    endcase
  end

  // ---------------- reference model ----------------
  // Evaluated at negedge: inputs are stable until the next rising edge.
  logic [DW-1:0] exp_q[$];
  int md_cnt = 0;
  bit md_clr = 0;
  bit md_ovr = 0;

  always @(negedge clk_50m) begin
    bit pop, cap, acc;
    if (!rst_n) begin
      md_cnt = 0;
      md_clr = 0;
      md_ovr = 0;
      exp_q.delete();
    end else begin
      check("rx_ready_clr", int'(bus.rx_ready_clr), int'(md_clr));
      check("count",        int'(bus.count),        md_cnt);
      check("m_valid",      int'(bus.m_valid),      int'(md_cnt != 0));
      check("overrun",      int'(bus.overrun),      int'(md_ovr));
      pop = (md_cnt != 0) && (bus.m_ready === 1'b1);
      cap = !md_clr && (bus.rx_ready === 1'b1);
      acc = cap && ((md_cnt < DEPTH) || pop);
      if (acc) exp_q.push_back(bus.rx_data);
      if (cap && !acc)                md_ovr = 1;
      else if (bus.overrun_clr === 1'b1) md_ovr = 0;
      md_cnt = md_cnt + int'(acc) - int'(pop);
      md_clr = cap;
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk_50m) begin
    logic [DW-1:0] e;
    if (rst_n && bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL scoreboard_underflow: got 0x%0h, expected no output", bus.m_data);
      end else begin
        e = exp_q.pop_front();
        check("m_data", int'(bus.m_data), int'(e));
      end
    end
  end

  // ---------------- behavioural receiver ----------------
  task automatic wait_clr();
    int k = 0;
    do begin
      @(posedge clk_50m); #1;
      k++;
    end while (bus.rx_ready_clr !== 1'b1 && k < 20);
    if (bus.rx_ready_clr !== 1'b1) begin
      n_checks++;
      $display("FAIL clr_timeout: got rx_ready_clr=%b, expected 1 within 20 cycles", bus.rx_ready_clr);
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input int gap);
    bus.rx_data  = d;
    bus.rx_ready = 1'b1;
    wait_clr();
    @(posedge clk_50m); #1;
    bus.rx_ready = 1'b0;
    repeat (gap) begin
      @(posedge clk_50m); #1;
    end
  endtask

  task automatic drain();
    mr_mode   = 0;
    mr_manual = 1'b1;
    for (int k = 0; k < 200 && bus.count != 0; k++) begin
      @(posedge clk_50m); #1;
    end
    check("drain_empty", int'(bus.count), 0);
    mr_manual = 1'b0;
    repeat (2) begin
      @(posedge clk_50m); #1;
    end
  endtask

  initial begin
    #(20 * 50000);
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n           = 1'b0;
    bus.rx_ready    = 1'b0;
    bus.rx_data     = '0;
    bus.overrun_clr = 1'b0;
    repeat (2) @(posedge clk_50m);
    #1;
    check("rst_count",   int'(bus.count),        0);
    check("rst_m_valid", int'(bus.m_valid),      0);
    check("rst_clr",     int'(bus.rx_ready_clr), 0);
    check("rst_overrun", int'(bus.overrun),      0);
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk_50m); #1; end

    // single frame, then one-cycle pop
    send(8'hA5, 2);
    check("single_data",  int'(bus.m_data), 8'hA5);
    check("single_count", int'(bus.count),  1);
    mr_manual = 1'b1;
    @(posedge clk_50m); #1;
    mr_manual = 1'b0;
    repeat (2) begin @(posedge clk_50m); #1; end
    check("single_popped", int'(bus.m_valid), 0);

    // burst fill to full, then drain in order
    for (int i = 0; i < 16; i++) send(8'(i), 0);
    repeat (2) begin @(posedge clk_50m); #1; end
    check("burst_count",   int'(bus.count),   16);
    check("burst_overrun", int'(bus.overrun), 0);
    drain();

    // overrun on full FIFO
    for (int i = 0; i < 16; i++) send(8'(8'h20 + i), 0);
    send(8'hEE, 1);
    check("ovr_flag",  int'(bus.overrun), 1);
    check("ovr_count", int'(bus.count),   16);
    bus.overrun_clr = 1'b1;
    @(posedge clk_50m); #1;
    bus.overrun_clr = 1'b0;
    check("ovr_cleared", int'(bus.overrun), 0);

    // simultaneous push and pop while full
    mr_manual    = 1'b1;
    bus.rx_data  = 8'h5A;
    bus.rx_ready = 1'b1;
    @(posedge clk_50m); #1;
    mr_manual = 1'b0;
    check("pp_clr", int'(bus.rx_ready_clr), 1);
    @(posedge clk_50m); #1;
    bus.rx_ready = 1'b0;
    repeat (2) begin @(posedge clk_50m); #1; end
    check("pp_count",   int'(bus.count),   16);
    check("pp_overrun", int'(bus.overrun), 0);
    drain();

    // pointer wrap with alternating sink ready
    mr_mode = 1;
    for (int i = 0; i < 40; i++) send(8'(8'h40 + i), 0);
    drain();

    // random frames, gaps, back-pressure and overrun clears
    mr_mode = 2;
    for (int i = 0; i < 80; i++) begin
      bus.overrun_clr = ($urandom_range(0, 7) == 0);
      send(8'($urandom), $urandom_range(0, 2));
    end
    bus.overrun_clr = 1'b0;
    drain();

    // reset asserted with count=5 while in CLR
    for (int i = 0; i < 4; i++) send(8'(8'h90 + i), 0);
    bus.rx_data  = 8'h77;
    bus.rx_ready = 1'b1;
    wait_clr();
    check("prerst_count", int'(bus.count), 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count",   int'(bus.count),        0);
    check("arst_m_valid", int'(bus.m_valid),      0);
    check("arst_clr",     int'(bus.rx_ready_clr), 0);
    check("arst_overrun", int'(bus.overrun),      0);
    bus.rx_ready = 1'b0;
    @(posedge clk_50m); #1;
    rst_n = 1'b1;
    send(8'h3C, 2);
    check("postrst_data",  int'(bus.m_data), 8'h3C);
    check("postrst_count", int'(bus.count),  1);
    drain();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
